// File: rtl/pending_encoder.sv
// Queues event pulses as pending bits and emits them one index per valid/ready handshake, lowest index first.
// Index appears two edges after the event; a stalled consumer holds out_idx while new events keep accumulating.
module pending_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     in,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  output logic [N-1:0]     pending,
  output logic             merged
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           r_state;
  logic [N-1:0]     r_pending;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_valid;
  logic             r_merged;

  logic [N-1:0]     w_cap;
  logic [N-1:0]     w_serve;
  logic [IDX_W-1:0] w_idx;
  logic             w_load;

  assign w_cap  = en ? in : '0;
  assign w_load = ((r_state == EMPTY) || out_ready) && (r_pending != '0);
  // Isolating the lowest set bit gives the one-hot of the index being loaded.
  assign w_serve = w_load ? (r_pending & (~r_pending + N'(1))) : '0;

  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_pending   <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_merged    <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_serve) | w_cap;
      r_merged  <= |(w_cap & r_pending & ~w_serve);
      case (r_state)
        EMPTY: begin
          if (w_load) begin
            r_state     <= FULL;
            r_out_valid <= 1'b1;
            r_out_idx   <= w_idx;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (w_load) begin
              r_out_idx <= w_idx;
            end else begin
              r_state     <= EMPTY;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_idx   = r_out_idx;
  assign out_valid = r_out_valid;
  assign pending   = r_pending;
  assign merged    = r_merged;

endmodule

// File: tb/tb_pending_encoder.sv
// Directed bench for pending_encoder: hand-computed output expectations after each rising edge.
module tb_pending_encoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] in;
  logic       out_ready;
  logic [1:0] out_idx;
  logic       out_valid;
  logic [3:0] pending;
  logic       merged;

  int n_tests = 0;
  int n_fail  = 0;

  pending_encoder #(.N(4), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .out_ready(out_ready),
    .out_idx(out_idx), .out_valid(out_valid), .pending(pending), .merged(merged)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [1:0] idx,
                         input logic [3:0] pend, input logic mrg);
    chk({tag, ".valid"},   {7'd0, out_valid}, {7'd0, v});
    chk({tag, ".idx"},     {6'd0, out_idx},   {6'd0, idx});
    chk({tag, ".pending"}, {4'd0, pending},   {4'd0, pend});
    chk({tag, ".merged"},  {7'd0, merged},    {7'd0, mrg});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in = 4'b0000; out_ready = 1'b1;
    #3;
    chk_all("reset_init", 1'b0, 2'd0, 4'b0000, 1'b0);
    #10 rst_n = 1'b1;
    tick();

    // Single event
    in = 4'b0100; tick();
    in = 4'b0000;
    chk_all("single_e1", 1'b0, 2'd0, 4'b0100, 1'b0);
    tick(); chk_all("single_e2", 1'b1, 2'd2, 4'b0000, 1'b0);
    tick(); chk_all("single_e3", 1'b0, 2'd2, 4'b0000, 1'b0);

    // Multi-hot drain with ready held high
    in = 4'b1011; tick();
    in = 4'b0000;
    chk_all("multi_e1", 1'b0, 2'd2, 4'b1011, 1'b0);
    tick(); chk_all("multi_d0", 1'b1, 2'd0, 4'b1010, 1'b0);
    tick(); chk_all("multi_d1", 1'b1, 2'd1, 4'b1000, 1'b0);
    tick(); chk_all("multi_d3", 1'b1, 2'd3, 4'b0000, 1'b0);
    tick(); chk_all("multi_end", 1'b0, 2'd3, 4'b0000, 1'b0);

    // Backpressure
    out_ready = 1'b0;
    in = 4'b0110; tick();
    in = 4'b0000;
    chk_all("bp_e1", 1'b0, 2'd3, 4'b0110, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(); chk_all($sformatf("bp_hold%0d", i), 1'b1, 2'd1, 4'b0100, 1'b0);
    end
    out_ready = 1'b1;
    tick(); chk_all("bp_d2", 1'b1, 2'd2, 4'b0000, 1'b0);
    tick(); chk_all("bp_end", 1'b0, 2'd2, 4'b0000, 1'b0);

    // Merge, en gating, event on held index
    out_ready = 1'b0;
    in = 4'b1001; tick();
    in = 4'b0000;
    tick(); chk_all("mg_load", 1'b1, 2'd0, 4'b1000, 1'b0);
    in = 4'b1000; tick();
    in = 4'b0000;
    chk_all("mg_pulse", 1'b1, 2'd0, 4'b1000, 1'b1);
    tick(); chk_all("mg_clear", 1'b1, 2'd0, 4'b1000, 1'b0);
    en = 1'b0; in = 4'b0001; tick();
    en = 1'b1; in = 4'b0000;
    chk_all("en_off", 1'b1, 2'd0, 4'b1000, 1'b0);
    in = 4'b0001; tick();
    in = 4'b0000;
    chk_all("held_idx_ev", 1'b1, 2'd0, 4'b1001, 1'b0);
    out_ready = 1'b1;
    tick(); chk_all("held_d0", 1'b1, 2'd0, 4'b1000, 1'b0);
    tick(); chk_all("held_d3", 1'b1, 2'd3, 4'b0000, 1'b0);
    tick(); chk_all("held_end", 1'b0, 2'd3, 4'b0000, 1'b0);

    // Same-cycle reload and re-arrive of index 0
    out_ready = 1'b0;
    in = 4'b0100; tick();
    in = 4'b0000;
    tick(); chk_all("sc_load2", 1'b1, 2'd2, 4'b0000, 1'b0);
    in = 4'b0001; tick();
    chk_all("sc_pend0", 1'b1, 2'd2, 4'b0001, 1'b0);
    out_ready = 1'b1;
    tick();
    in = 4'b0000;
    chk_all("sc_reload", 1'b1, 2'd0, 4'b0001, 1'b0);
    tick(); chk_all("sc_again", 1'b1, 2'd0, 4'b0000, 1'b0);
    tick(); chk_all("sc_end", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Asynchronous reset mid-cycle with state loaded
    out_ready = 1'b0;
    in = 4'b1011; tick();
    in = 4'b0000;
    tick(); chk_all("rst_pre", 1'b1, 2'd0, 4'b1010, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("rst_async", 1'b0, 2'd0, 4'b0000, 1'b0);
    #4 rst_n = 1'b1;
    tick(); chk_all("rst_after", 1'b0, 2'd0, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
